// File: rtl/input_conditioner.sv
// Conditions the game's raw push-buttons and guess switches: reset and input
// synchronization, per-button debounce with single-cycle press pulses, and a
// grouped debounce of the 4-bit switch bank.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_submit,
  input  logic       btn_next,
  input  logic [3:0] sw,
  output logic [3:0] data,
  output logic       submit,
  output logic       nextLevel
);

  localparam int unsigned NBTN = 2;
  localparam int unsigned SW_W = 4;
  localparam int unsigned NSYN = NBTN + SW_W;
  // Count value at which one more mismatching clock completes the debounce
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reset synchronizer: asserts asynchronously, releases on a clock edge
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Two-flop synchronizers, bit order {btn_next, btn_submit, sw[3:0]}
  logic [NSYN-1:0] meta_q;
  logic [NSYN-1:0] sync_q;
  logic [NBTN-1:0] btn_sync;
  logic [SW_W-1:0] sw_sync;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {btn_next, btn_submit, sw};
      sync_q <= meta_q;
    end
  end

  assign btn_sync = sync_q[NSYN-1:SW_W];
  assign sw_sync  = sync_q[SW_W-1:0];

  // Debounce state; button index 0 is submit, index 1 is next-level
  logic [NBTN-1:0][CNT_W-1:0] btn_cnt_q, btn_cnt_d;
  logic [NBTN-1:0]            btn_deb_q, btn_deb_d;
  logic [NBTN-1:0]            btn_prev_q;
  logic [CNT_W-1:0]           sw_cnt_q, sw_cnt_d;
  logic [SW_W-1:0]            sw_deb_q, sw_deb_d;

  // Per-button counters: run while input disagrees, flip state on the last count
  always_comb begin
    btn_cnt_d = '0;
    btn_deb_d = btn_deb_q;
    for (int unsigned i = 0; i < NBTN; i++) begin
      if (btn_sync[i] != btn_deb_q[i]) begin
        if (btn_cnt_q[i] == CNT_LAST) begin
          btn_deb_d[i] = ~btn_deb_q[i];
        end else begin
          btn_cnt_d[i] = btn_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Switch bank debounced as a group; loads whichever vector is present on settle
  always_comb begin
    sw_cnt_d = '0;
    sw_deb_d = sw_deb_q;
    if (sw_sync != sw_deb_q) begin
      if (sw_cnt_q == CNT_LAST) begin
        sw_deb_d = sw_sync;
      end else begin
        sw_cnt_d = sw_cnt_q + CNT_W'(1);
      end
    end
  end

  // Press pulses; a next-level press colliding with a submit press is deferred one cycle
  logic [NBTN-1:0] btn_rise;
  logic            submit_q, submit_d;
  logic            next_q, next_d;
  logic            pend_q, pend_d;
  logic [SW_W-1:0] data_q;

  always_comb begin
    btn_rise = btn_deb_q & ~btn_prev_q;
    submit_d = btn_rise[0];
    next_d   = (pend_q | btn_rise[1]) & ~btn_rise[0];
    pend_d   = btn_rise[0] ? (pend_q | btn_rise[1]) : (pend_q & btn_rise[1]);
  end

  // Core state registers; data is staged once so it lines up with the pulse path
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      btn_cnt_q  <= '0;
      btn_deb_q  <= '0;
      btn_prev_q <= '0;
      sw_cnt_q   <= '0;
      sw_deb_q   <= '0;
      submit_q   <= 1'b0;
      next_q     <= 1'b0;
      pend_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      btn_cnt_q  <= btn_cnt_d;
      btn_deb_q  <= btn_deb_d;
      btn_prev_q <= btn_deb_q;
      sw_cnt_q   <= sw_cnt_d;
      sw_deb_q   <= sw_deb_d;
      submit_q   <= submit_d;
      next_q     <= next_d;
      pend_q     <= pend_d;
      data_q     <= sw_deb_q;
    end
  end

  assign data      = data_q;
  assign submit    = submit_q;
  assign nextLevel = next_q;

endmodule
